// File: rtl/matrix_operand_loader_pkg.sv
// rtl/matrix_operand_loader_pkg.sv - shared constants and types for the matrix operand loader
package matload_pkg;

  localparam int MATLOAD_FRAME_LEN = 8;
  localparam int MATLOAD_DATA_W    = 8;

  localparam logic [2:0] IDX_A11 = 3'd0;
  localparam logic [2:0] IDX_A12 = 3'd1;
  localparam logic [2:0] IDX_A21 = 3'd2;
  localparam logic [2:0] IDX_A22 = 3'd3;
  localparam logic [2:0] IDX_B11 = 3'd4;
  localparam logic [2:0] IDX_B12 = 3'd5;
  localparam logic [2:0] IDX_B21 = 3'd6;
  localparam logic [2:0] IDX_B22 = 3'd7;

  typedef struct packed {
    logic [MATLOAD_FRAME_LEN-1:0][MATLOAD_DATA_W-1:0] elem;
    logic                                             relu;
    logic                                             full;
  } matload_slot_t;

  typedef enum logic {RD_IDLE, RD_PRESENT} rd_state_t;

endpackage

// File: rtl/matrix_operand_loader_if.sv
// rtl/matrix_operand_loader_if.sv - operand byte stream with valid/ready handshake
interface matrix_operand_loader_if #(parameter int DATA_W = 8) ();
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              in_relu;

  modport master (output in_valid, in_data, in_last, in_relu, input in_ready);
  modport slave  (input in_valid, in_data, in_last, in_relu, output in_ready);
endinterface

// File: rtl/matrix_operand_loader_slot.sv
// rtl/matrix_operand_loader_slot.sv - one frame store: 8 elements, relu flag and full bit
module matload_slot
  import matload_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     wrEn,
  input  logic [2:0]                               wrIdx,
  input  logic [DATA_W-1:0]                        wrData,
  input  logic                                     wrRelu,
  input  logic                                     setFull,
  input  logic                                     clrFull,
  output logic [MATLOAD_FRAME_LEN-1:0][DATA_W-1:0] elem,
  output logic                                     relu,
  output logic                                     full
);

  always_ff @(posedge clk) begin
    if (rst) begin
      elem <= '0;
      relu <= 1'b0;
      full <= 1'b0;
    end else begin
      if (wrEn) begin
        elem[wrIdx] <= wrData;
        if (wrIdx == IDX_A11) relu <= wrRelu;
      end
      if (setFull)      full <= 1'b1;
      else if (clrFull) full <= 1'b0;
    end
  end

endmodule

// File: rtl/matrix_operand_loader.sv
// rtl/matrix_operand_loader.sv - ping-pong frame loader feeding riscv_block operands
// Optional ack watchdog enabled by defining MATLOAD_WDOG_EN.
module matrix_operand_loader
  import matload_pkg::*;
#(
  parameter int DATA_W = 8
`ifdef MATLOAD_WDOG_EN
  , parameter int WDOG_CYCLES = 1024
`endif
) (
  input  logic                clk,
  input  logic                rst,
  matrix_operand_loader_if.slave s,
  output logic [DATA_W-1:0]   matrixA_11,
  output logic [DATA_W-1:0]   matrixA_12,
  output logic [DATA_W-1:0]   matrixA_21,
  output logic [DATA_W-1:0]   matrixA_22,
  output logic [DATA_W-1:0]   matrixB_11,
  output logic [DATA_W-1:0]   matrixB_12,
  output logic [DATA_W-1:0]   matrixB_21,
  output logic [DATA_W-1:0]   matrixB_22,
  output logic                ReLU,
  output logic                mat_valid,
  input  logic                mat_ack,
  output logic                frame_err,
  output logic [15:0]         frame_cnt
`ifdef MATLOAD_WDOG_EN
  , output logic              wdog_trip
`endif
);

  typedef logic [MATLOAD_FRAME_LEN-1:0][DATA_W-1:0] frame_t;

  logic       wp, rp;
  logic [2:0] byteIdx;
  logic [1:0] full, fullNow, slotRelu;
  frame_t     slotElem [2];
  frame_t     frameNow [2];
  frame_t     ops;
  rd_state_t  state, nextState;
  logic       accept, lastIdx, commit, discard, ack, loadOps, loadSel;

  assign s.in_ready = !rst && !full[wp];
  assign accept     = s.in_valid && s.in_ready;
  assign lastIdx    = (byteIdx == IDX_B22);
  assign commit     = accept && lastIdx && s.in_last;
  assign discard    = accept && (s.in_last != lastIdx);
  assign ack        = (state == RD_PRESENT) && mat_ack;

  for (genvar i = 0; i < 2; i++) begin : gSlot
    matload_slot #(.DATA_W(DATA_W)) uSlot (
      .clk     (clk),
      .rst     (rst),
      .wrEn    (accept && (wp == 1'(i))),
      .wrIdx   (byteIdx),
      .wrData  (s.in_data),
      .wrRelu  (s.in_relu),
      .setFull (commit && (wp == 1'(i))),
      .clrFull (ack && (rp == 1'(i))),
      .elem    (slotElem[i]),
      .relu    (slotRelu[i]),
      .full    (full[i])
    );
  end

  // A committing byte is forwarded so a fresh frame presents one cycle after its last byte.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      frameNow[i] = slotElem[i];
      fullNow[i]  = full[i];
      if (commit && (wp == 1'(i))) begin
        frameNow[i][IDX_B22] = s.in_data;
        fullNow[i]           = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byteIdx   <= '0;
      wp        <= 1'b0;
      rp        <= 1'b0;
      frame_err <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (accept) byteIdx <= (commit || discard) ? 3'd0 : byteIdx + 3'd1;
      if (commit) wp <= !wp;
      if (ack) begin
        rp        <= !rp;
        frame_cnt <= frame_cnt + 16'd1;
      end
      frame_err <= discard;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= RD_IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      RD_IDLE:    if (fullNow[rp]) nextState = RD_PRESENT;
      RD_PRESENT: if (ack)         nextState = fullNow[!rp] ? RD_PRESENT : RD_IDLE;
      default:    nextState = RD_IDLE;
    endcase
  end

  always_comb begin
    loadOps = 1'b0;
    loadSel = rp;
    case (state)
      RD_IDLE:    loadOps = fullNow[rp];
      RD_PRESENT: if (ack && fullNow[!rp]) begin
        loadOps = 1'b1;
        loadSel = !rp;
      end
      default:    loadOps = 1'b0;
    endcase
  end

  assign mat_valid = (state == RD_PRESENT);

  always_ff @(posedge clk) begin
    if (rst) begin
      ops  <= '0;
      ReLU <= 1'b0;
    end else if (loadOps) begin
      ops  <= frameNow[loadSel];
      ReLU <= slotRelu[loadSel];
    end
  end

  assign matrixA_11 = ops[IDX_A11];
  assign matrixA_12 = ops[IDX_A12];
  assign matrixA_21 = ops[IDX_A21];
  assign matrixA_22 = ops[IDX_A22];
  assign matrixB_11 = ops[IDX_B11];
  assign matrixB_12 = ops[IDX_B12];
  assign matrixB_21 = ops[IDX_B21];
  assign matrixB_22 = ops[IDX_B22];

`ifdef MATLOAD_WDOG_EN
  localparam int WDOG_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  logic [WDOG_W-1:0] wdogCnt;

  // Count saturates at the limit; the trip flag is sticky until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdogCnt   <= '0;
      wdog_trip <= 1'b0;
    end else if (mat_valid && !mat_ack) begin
      if (wdogCnt == WDOG_W'(WDOG_CYCLES - 1)) wdog_trip <= 1'b1;
      else                                    wdogCnt   <= wdogCnt + 1'b1;
    end else begin
      wdogCnt <= '0;
    end
  end
`endif

endmodule
